// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths and arbiter state encoding for the cache/memory block bus.
package mem_bus_pkg;
    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} arb_state_t;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-requester round-robin grant; remembers which port was served last.
// Ports: CLK/RESET (async active-low), req_i/req_d requests, done pulses when a
// transfer completes with done_d naming the port served, grant_d selects data port.
module rr_grant2 (
    input  logic CLK,
    input  logic RESET,
    input  logic req_i,
    input  logic req_d,
    input  logic done,
    input  logic done_d,
    output logic grant_d
);
    logic last_d;
    // Data wins unless instruction also wants the bus and data was served last.
    assign grant_d = req_d & (~req_i | ~last_d);
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) last_d <= 1'b0;
        else if (done) last_d <= done_d;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises I-cache and D-cache block requests onto one block memory.
// Ports: CLK/RESET (async active-low); i_* instruction-cache read port; d_* data-cache
// read/write port; m_* memory-side initiator bus. Busywaits are combinational so a
// fresh request stalls its cache in the same cycle; all memory-side outputs are registered.
import mem_bus_pkg::*;
module mem_bus_arbiter (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               m_read,
    output logic               m_write,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BLOCK_W-1:0] m_writedata,
    input  logic [BLOCK_W-1:0] m_readdata,
    input  logic               m_busywait
);
    arb_state_t state;
    logic pend_i, pend_d, grant_d, done;
    assign pend_i     = i_read;
    assign pend_d     = d_read | d_write;
    assign done       = (state == BUSY_I || state == BUSY_D) && !m_busywait;
    assign i_busywait = pend_i & (state != DONE_I);
    assign d_busywait = pend_d & (state != DONE_D);
    rr_grant2 u_rr (
        .CLK     (CLK),
        .RESET   (RESET),
        .req_i   (pend_i),
        .req_d   (pend_d),
        .done    (done),
        .done_d  (state == BUSY_D),
        .grant_d (grant_d)
    );
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            i_readdata  <= '0;
            d_readdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A simultaneous read+write is a write-back.
                        state       <= BUSY_D;
                        m_read      <= ~d_write;
                        m_write     <= d_write;
                        m_address   <= d_address;
                        m_writedata <= d_writedata;
                    end else if (pend_i) begin
                        state       <= BUSY_I;
                        m_read      <= 1'b1;
                        m_write     <= 1'b0;
                        m_address   <= i_address;
                        m_writedata <= '0;
                    end
                end
                BUSY_I: begin
                    if (!m_busywait) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        // An abandoned request still finishes on the memory side,
                        // but its data is dropped and nobody needs a DONE cycle.
                        if (pend_i) i_readdata <= m_readdata;
                        state <= pend_i ? DONE_I : IDLE;
                    end
                end
                BUSY_D: begin
                    if (!m_busywait) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (pend_d && m_read) d_readdata <= m_readdata;
                        state <= pend_d ? DONE_D : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with a latency-programmable memory model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;
    logic CLK = 1'b0, RESET = 1'b1;
    logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [ADDR_W-1:0] i_address = '0, d_address = '0, m_address;
    logic [BLOCK_W-1:0] d_writedata = '0, i_readdata, d_readdata, m_writedata, m_readdata;
    logic i_busywait, d_busywait, m_read, m_write, m_busywait;
    int checks = 0, errors = 0;
    int mem_n = 4, mcnt;
    logic [BLOCK_W-1:0] rd_tbl [16];
    typedef struct packed {
        logic rd;
        logic wr;
        logic [ADDR_W-1:0] a;
        logic [BLOCK_W-1:0] wd;
    } mreq_t;
    mreq_t mq[$];
    logic [BLOCK_W-1:0] iq[$], dq[$];
    mreq_t cur = '0;
    logic strobe_q = 1'b0;

    always #5 CLK = ~CLK;

    mem_bus_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_busywait(m_busywait)
    );

    // Memory: busy for mem_n cycles starting the cycle a strobe rises, reset by the same RESET.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) mcnt <= 0;
        else mcnt <= (m_read | m_write) ? mcnt + 1 : 0;
    end
    assign m_busywait = (m_read | m_write) && (mcnt < mem_n);
    assign m_readdata = rd_tbl[m_address[7:4]];

    function automatic mreq_t mreq(input logic rd, input logic wr, input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] wd);
        mreq = {rd, wr, a, wd};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-side monitor: each strobe rise pops one expected request, held until it drops.
    always @(negedge RESET) strobe_q = 1'b0;
    always @(negedge CLK) begin
        if ((m_read | m_write) && !strobe_q) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got strobe at address %0h, expected none", m_address);
            end else cur = mq.pop_front();
        end
        if (m_read | m_write) chk("mem_req", {m_read, m_write, m_address, m_writedata}, cur);
        strobe_q = m_read | m_write;
    end

    // Cache-side monitor: a completed request pops its expected block.
    always @(negedge CLK) begin
        if (i_read && !i_busywait) begin
            if (iq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL i_unexpected_done: got completion, expected none");
            end else chk("i_readdata", i_readdata, iq.pop_front());
        end
        if ((d_read | d_write) && !d_busywait) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected_done: got completion, expected none");
            end else chk("d_readdata", d_readdata, dq.pop_front());
        end
        if (RESET && !i_read) chk("i_busywait_idle", i_busywait, 0);
        if (RESET && !(d_read | d_write)) chk("d_busywait_idle", d_busywait, 0);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b0;
        tick;
        RESET = 1'b1;
    endtask

    task automatic wait_done(input bit is_d, input string name, input int exp_c);
        int c = 0;
        @(negedge CLK);
        while ((is_d ? d_busywait : i_busywait) && c < 40) begin
            @(negedge CLK);
            c++;
        end
        chk(name, c, exp_c);
        tick;
        if (is_d) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end else i_read = 1'b0;
    endtask

    task automatic contend(input string name, input int exp_dd, input int exp_di, input int exp_rise, input logic [ADDR_W-1:0] second_addr);
        int dd = -1, di = -1, ri = -1;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int c = 0; c < 40 && (dd < 0 || di < 0); c++) begin
            @(negedge CLK);
            if (dd < 0 && d_read && !d_busywait) dd = c;
            if (di < 0 && i_read && !i_busywait) di = c;
            if (ri < 0 && m_read && m_address == second_addr) ri = c;
            tick;
            if (dd == c) d_read = 1'b0;
            if (di == c) i_read = 1'b0;
        end
        chk({name, "_d_done"}, dd, exp_dd);
        chk({name, "_i_done"}, di, exp_di);
        chk({name, "_second_rise"}, ri, exp_rise);
    endtask

    initial begin
        int c;
        for (int k = 0; k < 16; k++) rd_tbl[k] = {4{32'h1000_0000 + 32'(k)}};
        rd_tbl[1] = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
        #1 RESET = 1'b0;
        #2;
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_writedata", m_writedata, 0);
        chk("rst_i_readdata", i_readdata, 0);
        chk("rst_d_readdata", d_readdata, 0);
        chk("rst_i_busywait", i_busywait, 0);
        chk("rst_d_busywait", d_busywait, 0);
        chk("rst_state", dut.state, IDLE);
        tick;
        RESET = 1'b1;
        tick;
        // Isolated instruction fetch, memory busy 4 cycles.
        mem_n = 4;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000010, '0));
        iq.push_back(128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501);
        i_address = 28'h0000010;
        i_read = 1'b1;
        wait_done(1'b0, "i_fetch_latency", 6);
        // Data write-back; d_readdata must stay 0.
        mem_n = 3;
        mq.push_back(mreq(1'b0, 1'b1, 28'h0000020, {4{32'hDEADBEEF}}));
        dq.push_back('0);
        d_address = 28'h0000020;
        d_writedata = {4{32'hDEADBEEF}};
        d_write = 1'b1;
        wait_done(1'b1, "d_write_latency", 5);
        // Simultaneous reads after reset: data first, instruction strobe 2 cycles after DONE_D.
        do_reset;
        tick;
        mem_n = 2;
        i_address = 28'h0000040;
        d_address = 28'h0000050;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000050, {4{32'hDEADBEEF}}));
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000040, '0));
        dq.push_back(rd_tbl[5]);
        iq.push_back(rd_tbl[4]);
        contend("pair1", 4, 9, 6, 28'h0000040);
        // Lone data read makes data the last-served port.
        mem_n = 1;
        d_address = 28'h0000030;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000030, {4{32'hDEADBEEF}}));
        dq.push_back(rd_tbl[3]);
        d_read = 1'b1;
        wait_done(1'b1, "d_read_latency", 3);
        // Next simultaneous pair goes to the instruction port first.
        i_address = 28'h0000080;
        d_address = 28'h0000090;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000080, '0));
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000090, {4{32'hDEADBEEF}}));
        iq.push_back(rd_tbl[8]);
        dq.push_back(rd_tbl[9]);
        contend("pair2", 7, 3, 5, 28'h0000090);
        // Read and write together behave as a write only.
        mem_n = 2;
        d_address = 28'h00000A0;
        d_writedata = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        mq.push_back(mreq(1'b0, 1'b1, 28'h00000A0, 128'h01234567_89ABCDEF_FEDCBA98_76543210));
        dq.push_back(rd_tbl[9]);
        d_read = 1'b1;
        d_write = 1'b1;
        wait_done(1'b1, "d_rw_latency", 4);
        // Reset pulse during BUSY_I; held request restarts afterwards.
        mem_n = 6;
        i_address = 28'h0000060;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000060, '0));
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000060, '0));
        iq.push_back(rd_tbl[6]);
        i_read = 1'b1;
        tick;
        tick;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("midrst_m_read", m_read, 0);
        chk("midrst_i_readdata", i_readdata, 0);
        #1 RESET = 1'b1;
        #1;
        chk("midrst_state", dut.state, IDLE);
        chk("midrst_i_busywait", i_busywait, 1);
        wait_done(1'b0, "i_restart_latency", 7);
        // Fetch a known block, then abandon a second fetch mid-flight.
        mem_n = 1;
        i_address = 28'h0000010;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000010, '0));
        iq.push_back(rd_tbl[1]);
        i_read = 1'b1;
        wait_done(1'b0, "i_fetch2_latency", 3);
        mem_n = 4;
        i_address = 28'h0000070;
        mq.push_back(mreq(1'b1, 1'b0, 28'h0000070, '0));
        i_read = 1'b1;
        tick;
        tick;
        i_read = 1'b0;
        c = 0;
        @(negedge CLK);
        while (m_read && c < 40) begin
            @(negedge CLK);
            c++;
        end
        chk("drop_strobe_hold", c, 4);
        chk("drop_i_readdata", i_readdata, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501);
        chk("drop_state", dut.state, IDLE);
        tick;
        tick;
        chk("mq_drained", mq.size(), 0);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
